mem_access_unit: RTL and testbench

- Memory-access stage between the execute stage and the word-addressed test data memory.
- Converts RISC-V byte-addressed load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide memory reads and writes.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores, because the memory only writes whole words.
- Runs on the posedge; the memory runs on the negedge of the same clock.

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and word-memory signals of the memory-access stage.
// The slave modport is the unit's view. The master modport is the execute stage and memory side.
interface mem_access_unit_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          valid_i;
    logic          we_i;
    logic [2:0]    funct3_i;
    logic [DW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [DW-1:0] load_data_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_rd_en_o;
    logic          mem_wr_en_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    modport slave (
        input  valid_i, we_i, funct3_i, addr_i, wdata_i, mem_rdata_i,
        output busy_o, done_o, err_o, load_data_o, mem_addr_o, mem_rd_en_o, mem_wr_en_o,
               mem_wdata_o
    );

    modport master (
        output valid_i, we_i, funct3_i, addr_i, wdata_i, mem_rdata_i,
        input  busy_o, done_o, err_o, load_data_o, mem_addr_o, mem_rd_en_o, mem_wr_en_o,
               mem_wdata_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed RISC-V load/store front end for a word-wide memory clocked on the negedge.
// Sub-word stores are done as read-modify-write.
module mem_access_unit #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_access_unit_if.slave    bus
);
    typedef enum logic [1:0] {StIdle, StLd, StStRd, StStWr} state_e;

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [DW-1:0] load_data_q, load_data_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          rd_en_q, rd_en_d;
    logic          wr_en_q, wr_en_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] st_data_q, st_data_d;
    logic [1:0]    off_q, off_d;
    logic [2:0]    f3_q, f3_d;

    logic          req_err;
    logic [4:0]    sh;
    logic [DW-1:0] lane, mask, merged, ext;

    // Request legality, evaluated against the live inputs in idle.
    always_comb begin
        req_err = 1'b0;
        unique case (bus.funct3_i)
            3'b000, 3'b010:  req_err = 1'b0;
            3'b001:          req_err = bus.addr_i[0];
            3'b100, 3'b101:  req_err = bus.we_i | (bus.funct3_i[0] & bus.addr_i[0]);
            default:         req_err = 1'b1;
        endcase
        if (bus.funct3_i == 3'b010 && bus.addr_i[1:0] != 2'b00) req_err = 1'b1;
        if (bus.addr_i[DW-1:AW+2] != '0) req_err = 1'b1;
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        sh   = {off_q, 3'b000};
        lane = bus.mem_rdata_i >> sh;
        if (f3_q[0]) begin
            mask = {{(DW-16){1'b0}}, 16'hFFFF} << sh;
            ext  = {{(DW-16){lane[15] & ~f3_q[2]}}, lane[15:0]};
        end else begin
            mask = {{(DW-8){1'b0}}, 8'hFF} << sh;
            ext  = {{(DW-8){lane[7] & ~f3_q[2]}}, lane[7:0]};
        end
        if (f3_q[1:0] == 2'b10) ext = bus.mem_rdata_i;
        merged = (bus.mem_rdata_i & ~mask) | ((st_data_q << sh) & mask);
    end

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load_data_d = load_data_q;
        mem_addr_d  = mem_addr_q;
        rd_en_d     = rd_en_q;
        wr_en_d     = wr_en_q;
        mem_wdata_d = mem_wdata_q;
        st_data_d   = st_data_q;
        off_d       = off_q;
        f3_d        = f3_q;
        unique case (state_q)
            StIdle: begin
                if (bus.valid_i) begin
                    if (req_err) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        mem_addr_d = bus.addr_i[AW+1:2];
                        off_d      = bus.addr_i[1:0];
                        f3_d       = bus.funct3_i;
                        if (!bus.we_i) begin
                            rd_en_d = 1'b1;
                            state_d = StLd;
                        end else if (bus.funct3_i == 3'b010) begin
                            wr_en_d     = 1'b1;
                            mem_wdata_d = bus.wdata_i;
                            state_d     = StStWr;
                        end else begin
                            rd_en_d   = 1'b1;
                            st_data_d = bus.wdata_i;
                            state_d   = StStRd;
                        end
                    end
                end
            end
            StLd: begin
                rd_en_d     = 1'b0;
                load_data_d = ext;
                done_d      = 1'b1;
                state_d     = StIdle;
            end
            StStRd: begin
                rd_en_d     = 1'b0;
                wr_en_d     = 1'b1;
                mem_wdata_d = merged;
                state_d     = StStWr;
            end
            StStWr: begin
                wr_en_d = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= '0;
            mem_addr_q  <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            mem_wdata_q <= '0;
            st_data_q   <= '0;
            off_q       <= '0;
            f3_q        <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
            mem_addr_q  <= mem_addr_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            mem_wdata_q <= mem_wdata_d;
            st_data_q   <= st_data_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.load_data_o = load_data_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_rd_en_o = rd_en_q;
    assign bus.mem_wr_en_o = wr_en_q;
    assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: negedge word memory model plus a scoreboard of expected
// completions (error flag, load data, latency).
module tb_mem_access_unit;
    typedef struct {
        string       tag;
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] mem [32];
    exp_t        sb_q [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    mem_access_unit_if #(.DW(32), .AW(5)) bus ();

    mem_access_unit #(.DW(32), .AW(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (bus.mem_wr_en_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
        if (bus.mem_rd_en_o) bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        check("rd_wr_exclusive", {31'd0, bus.mem_rd_en_o & bus.mem_wr_en_o}, 32'd0);
    endtask

    task automatic push(input string tag, input logic err, input logic chk,
                        input logic [31:0] data, input int lat);
        exp_t e;
        e.tag = tag; e.err = err; e.chk = chk; e.data = data; e.lat = lat;
        sb_q.push_back(e);
    endtask

    // Present a request for exactly one edge (edge N); cyc counts edges after N.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.valid_i  = 1'b1;
        bus.we_i     = we;
        bus.funct3_i = f3;
        bus.addr_i   = addr;
        bus.wdata_i  = wdata;
        tick();
        bus.valid_i = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_done();
        exp_t e;
        while (!bus.done_o && cyc < 8) tick();
        if (!bus.done_o) begin
            check("done_timeout", 32'd0, 32'd1);
        end else if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_lat"}, cyc, e.lat);
            check({e.tag, "_err"}, {31'd0, bus.err_o}, {31'd0, e.err});
            if (e.chk) check({e.tag, "_data"}, bus.load_data_o, e.data);
        end
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] exp);
        push(tag, 1'b0, 1'b1, exp, 1);
        issue(1'b0, f3, addr, 32'd0);
        wait_done();
    endtask

    task automatic bad(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr);
        push(tag, 1'b1, 1'b0, 32'd0, 0);
        issue(we, f3, addr, 32'hDEADBEEF);
        check({tag, "_noen"}, {30'd0, bus.mem_rd_en_o, bus.mem_wr_en_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'(12 * i);
        bus.valid_i = 1'b0; bus.we_i = 1'b0; bus.funct3_i = 3'd0;
        bus.addr_i = 32'd0; bus.wdata_i = 32'd0; bus.mem_rdata_i = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_outs", {bus.busy_o, bus.done_o, bus.err_o, bus.mem_rd_en_o,
              bus.mem_wr_en_o, 27'd0}, 32'd0);
        check("reset_vec", bus.load_data_o | bus.mem_wdata_o | {27'd0, bus.mem_addr_o}, 32'd0);
        rst_i = 1'b1;

        push("lw4", 1'b0, 1'b1, 32'h0000000C, 1);
        issue(1'b0, 3'b010, 32'h4, 32'd0);
        check("lw4_rd_en", {31'd0, bus.mem_rd_en_o}, 32'd1);
        check("lw4_addr", {27'd0, bus.mem_addr_o}, 32'd1);
        check("lw4_busy", {31'd0, bus.busy_o}, 32'd1);
        wait_done();
        check("lw4_rd_off", {31'd0, bus.mem_rd_en_o}, 32'd0);

        push("sw8", 1'b0, 1'b0, 32'd0, 1);
        issue(1'b1, 3'b010, 32'h8, 32'h8081F0F7);
        check("sw8_wr_en", {30'd0, bus.mem_rd_en_o, bus.mem_wr_en_o}, 32'd1);
        check("sw8_wdata", bus.mem_wdata_o, 32'h8081F0F7);
        wait_done();

        load("lb8", 3'b000, 32'h8, 32'hFFFFFFF7);
        load("lbu9", 3'b100, 32'h9, 32'h000000F0);
        load("lha", 3'b001, 32'hA, 32'hFFFF8081);
        load("lhua", 3'b101, 32'hA, 32'h00008081);
        load("lw8", 3'b010, 32'h8, 32'h8081F0F7);

        push("sb5", 1'b0, 1'b0, 32'd0, 2);
        issue(1'b1, 3'b000, 32'h5, 32'h123456AB);
        check("sb5_rd", {30'd0, bus.mem_rd_en_o, bus.mem_wr_en_o}, 32'd2);
        tick();
        check("sb5_wr", {30'd0, bus.mem_rd_en_o, bus.mem_wr_en_o}, 32'd1);
        check("sb5_wdata", bus.mem_wdata_o, 32'h0000AB0C);
        check("sb5_nodone", {31'd0, bus.done_o}, 32'd0);
        wait_done();
        load("lw4_after_sb", 3'b010, 32'h4, 32'h0000AB0C);

        bad("err_lw6", 1'b0, 3'b010, 32'h6);
        bad("err_lh3", 1'b0, 3'b001, 32'h3);
        bad("err_lw80", 1'b0, 3'b010, 32'h80);
        bad("err_f3_011", 1'b0, 3'b011, 32'h0);
        bad("err_st_f3_100", 1'b1, 3'b100, 32'h4);
        check("err_ld_keep", bus.load_data_o, 32'h0000AB0C);
        load("lw4_after_err", 3'b010, 32'h4, 32'h0000AB0C);

        // Reset lands while the SH write is pending; the negedge write must not happen.
        issue(1'b1, 3'b001, 32'h10, 32'h00005A5A);
        tick();
        check("sh_wr_before_rst", {31'd0, bus.mem_wr_en_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check("rst_mid", {29'd0, bus.mem_wr_en_o, bus.busy_o, bus.done_o}, 32'd0);
        #1;
        rst_i = 1'b1;
        tick();
        check("rst_idle", {30'd0, bus.busy_o, bus.done_o}, 32'd0);
        load("lw10_untouched", 3'b010, 32'h10, 32'h00000030);

        // valid held through a sub-word store: one op per done, re-accept right after done.
        bus.valid_i = 1'b1; bus.we_i = 1'b1; bus.funct3_i = 3'b000;
        bus.addr_i = 32'h11; bus.wdata_i = 32'h000000EE;
        tick();
        check("hold_e0", {29'd0, bus.busy_o, bus.mem_rd_en_o, bus.done_o}, 32'd6);
        tick();
        check("hold_e1", {29'd0, bus.busy_o, bus.mem_wr_en_o, bus.done_o}, 32'd6);
        tick();
        check("hold_e2", {29'd0, bus.busy_o, bus.mem_rd_en_o, bus.done_o}, 32'd1);
        tick();
        bus.valid_i = 1'b0;
        check("hold_e3", {29'd0, bus.busy_o, bus.mem_rd_en_o, bus.done_o}, 32'd6);
        tick();
        check("hold_e4", {30'd0, bus.busy_o, bus.done_o}, 32'd2);
        tick();
        check("hold_e5", {30'd0, bus.busy_o, bus.done_o}, 32'd1);
        tick();
        check("hold_e6", {30'd0, bus.busy_o, bus.done_o}, 32'd0);
        load("lw10_after_sb", 3'b010, 32'h10, 32'h0000EE30);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
